// File: rtl/axi_lite_slave_mem_if.sv
// rtl/axi_lite_slave_mem_if.sv - AXI-lite AR/R/AW/W/B channel bundle for the register memory slave
interface axi_lite_slave_mem_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_W-1:0]     ar_addr;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_W-1:0]     r_data;
   logic [1:0]            rresp;
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     aw_addr;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     w_data;
   logic [DATA_W/8-1:0]   w_strb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;

   modport slave (
      input  arvalid, ar_addr, rready, awvalid, aw_addr, wvalid, w_data, w_strb, bready,
      output arready, rvalid, r_data, rresp, awready, wready, bvalid, bresp
   );

   modport master (
      output arvalid, ar_addr, rready, awvalid, aw_addr, wvalid, w_data, w_strb, bready,
      input  arready, rvalid, r_data, rresp, awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// rtl/axi_lite_slave_mem.sv - AXI-lite slave terminating AR/R/AW/W/B onto a word-addressed register memory
module axi_lite_slave_mem #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   axi_lite_slave_mem_if.slave  bus
);
   localparam int BYTES   = DATA_W / 8;
   localparam int BYTE_LG = $clog2(BYTES);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int SPAN_LG = IDX_W + BYTE_LG;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // The window is a power-of-two span, so "off < span" is "no bits above the span".
   function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] off;
      off = addr - BASE_ADDR;
      return (addr >= BASE_ADDR) && ((off >> SPAN_LG) == '0);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] off;
      off = addr - BASE_ADDR;
      return IDX_W'(off >> BYTE_LG);
   endfunction

   typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;

   logic [DATA_W-1:0] mem [DEPTH];

   wstate_t           wstate;
   logic              awready_q, wready_q, bvalid_q;
   logic [1:0]        bresp_q;
   logic [ADDR_W-1:0] aw_addr_q;
   logic [DATA_W-1:0] w_data_q;
   logic [BYTES-1:0]  w_strb_q;

   rstate_t           rstate;
   logic              arready_q, rvalid_q;
   logic [DATA_W-1:0] r_data_q;
   logic [1:0]        rresp_q;

   logic              aw_hs, w_hs, ar_hs;
   logic              wr_commit;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [BYTES-1:0]  wr_strb;
   logic [IDX_W-1:0]  wr_idx;

   assign aw_hs = bus.awvalid & awready_q;
   assign w_hs  = bus.wvalid  & wready_q;
   assign ar_hs = bus.arvalid & arready_q;

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.r_data  = r_data_q;
   assign bus.rresp   = rresp_q;

   // The commit uses the live bus value for whichever half arrives on the completing edge.
   always_comb begin
      wr_commit = 1'b0;
      wr_addr   = aw_addr_q;
      wr_data   = w_data_q;
      wr_strb   = w_strb_q;
      case (wstate)
         W_IDLE: begin
            wr_commit = aw_hs & w_hs;
            wr_addr   = bus.aw_addr;
            wr_data   = bus.w_data;
            wr_strb   = bus.w_strb;
         end
         W_GOT_AW: begin
            wr_commit = w_hs;
            wr_data   = bus.w_data;
            wr_strb   = bus.w_strb;
         end
         W_GOT_W: begin
            wr_commit = aw_hs;
            wr_addr   = bus.aw_addr;
         end
         default: wr_commit = 1'b0;
      endcase
   end

   assign wr_idx = addr_idx(wr_addr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wstate    <= W_IDLE;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (aw_hs) aw_addr_q <= bus.aw_addr;
         if (w_hs) begin
            w_data_q <= bus.w_data;
            w_strb_q <= bus.w_strb;
         end
         if (wr_commit) begin
            wstate    <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= addr_ok(wr_addr) ? RESP_OKAY : RESP_SLVERR;
         end else begin
            case (wstate)
               W_IDLE: begin
                  if (aw_hs) begin
                     wstate    <= W_GOT_AW;
                     awready_q <= 1'b0;
                  end else if (w_hs) begin
                     wstate   <= W_GOT_W;
                     wready_q <= 1'b0;
                  end
               end
               W_RESP: begin
                  if (bus.bready) begin
                     wstate    <= W_IDLE;
                     awready_q <= 1'b1;
                     wready_q  <= 1'b1;
                     bvalid_q  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_commit && addr_ok(wr_addr)) begin
         for (int b = 0; b < BYTES; b++)
            if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   // Reading mem with a nonblocking update pending gives pre-write data on a same-edge collision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rstate    <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         r_data_q  <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (ar_hs) begin
                  rstate    <= R_DATA;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  r_data_q  <= addr_ok(bus.ar_addr) ? mem[addr_idx(bus.ar_addr)] : '0;
                  rresp_q   <= addr_ok(bus.ar_addr) ? RESP_OKAY : RESP_SLVERR;
               end
            end
            R_DATA: begin
               if (bus.rready) begin
                  rstate    <= R_IDLE;
                  arready_q <= 1'b1;
                  rvalid_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/axi_lite_slave_mem.md
# axi_lite_slave_mem

Parametrised AXI-lite slave that terminates the five AXI channels (AR, R, AW, W, B) onto an internal word-addressed register memory. It is the successor to the fixed 32-bit, response-less read/write slave. It adds configurable address and data width, configurable depth and base address, write byte strobes, a read response channel, and out-of-range error signalling. It sits behind the testbench/DUT interface bundle as the DUT-side endpoint, or as a scratch memory in larger fabrics.

## Interface
- ADDR_W, 32: address width of ar_addr and aw_addr.
- DATA_W, 32: data width; must be 32 or 64.
- DEPTH, 256: number of DATA_W-bit words; must be a power of 2, at least 2.
- BASE_ADDR, 0: byte address of word 0; must be aligned to DEPTH*DATA_W/8.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- arvalid, arready  in/out  1  read address handshake.
- ar_addr  in  ADDR_W  read byte address.
- rvalid, rready  out/in  1  read data handshake.
- r_data  out  DATA_W  read data.
- rresp  out  2  read response.
- awvalid, awready  in/out  1  write address handshake.
- aw_addr  in  ADDR_W  write byte address.
- wvalid, wready  in/out  1  write data handshake.
- w_data  in  DATA_W  write data.
- w_strb  in  DATA_W/8  byte enables; bit i covers w_data[8i+7:8i].
- bvalid, bready  out/in  1  write response handshake.
- bresp  out  2  write response.

## Operation
- Address decode: off = addr - BASE_ADDR. The address is in range iff addr >= BASE_ADDR and off < DEPTH*DATA_W/8. The word index is off >> log2(DATA_W/8); the low byte-offset bits are ignored.
- Responses: 2'b00 OKAY, 2'b10 SLVERR. SLVERR is returned only for an out-of-range address.
- Memory: all words are cleared to 0 on reset.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_GOT_AW: awready=0, wready=1. The address is latched.
  - W_GOT_W: awready=1, wready=0. Data and strobe are latched.
  - W_RESP: awready=0, wready=0, bvalid=1.
- Write transitions:
  - W_IDLE with both AW and W handshakes in the same cycle goes to W_RESP.
  - W_IDLE with AW only goes to W_GOT_AW; with W only it goes to W_GOT_W.
  - W_GOT_AW with a W handshake goes to W_RESP; W_GOT_W with an AW handshake goes to W_RESP.
  - W_RESP with bvalid&bready goes to W_IDLE.
- Write commit: on the edge that enters W_RESP, if the address is in range, each byte whose strobe bit is set is written. If out of range, the memory is unchanged. bresp is registered on the same edge and held stable while bvalid=1.
- Read FSM states:
  - R_IDLE: arready=1, rvalid=0.
  - R_DATA: arready=0, rvalid=1.
- Read transitions:
  - An AR handshake in R_IDLE goes to R_DATA. r_data and rresp are registered on that edge. Out-of-range reads return r_data=0 and rresp=SLVERR.
  - R_DATA with rready goes to R_IDLE.
- r_data and rresp are held stable while rvalid=1.
- The read and write FSMs are fully independent.
- Read/write collision: if an AR handshake and a write commit to the same word land on the same edge, the read returns the pre-write data.

## Timing
- Outputs while rst is low:
  - arready=1, awready=1, wready=1 (the ready signals are decoded from state; both FSMs are in their IDLE state).
  - rvalid=0, bvalid=0.
  - r_data=0, rresp=0, bresp=0.
- Reset asserted mid-transaction aborts it immediately. Outputs return to the reset values and the memory is cleared. No partial write is kept beyond edges already taken.
- Write latency: bvalid rises 1 cycle after the later of the AW and W handshakes. The ready signals rise 1 cycle after the B handshake.
- Write throughput: at best 1 write per 2 cycles (AW+W together, then bready held high).
- Read latency: rvalid rises 1 cycle after the AR handshake. arready rises 1 cycle after the R handshake.
- Read throughput: at best 1 read per 2 cycles.
- No combinational path exists from any valid or ready input to any output.
- Inputs are sampled only when the matching valid&ready pair is high. Address and data inputs are don't-care otherwise.

## Test plan
- Reset: hold rst low for 3 cycles, release. Required: arready=awready=wready=1, rvalid=bvalid=0. A read of BASE_ADDR then returns r_data=0 with rresp=00.
- AW and W together: aw_addr=0x10, w_data=0xDEADBEEF, w_strb=0xF in one cycle. Required: bvalid=1 next cycle with bresp=00. A read of 0x10 returns 0xDEADBEEF.
- W before AW with partial strobe: send W first with w_data=0x11223344, w_strb=4'b0101 over a word holding 0xDEADBEEF, then AW 2 cycles later. Required: wready=0 while waiting for AW. The word becomes 0xDE22BE44.
- Out of range (DEPTH=256, DATA_W=32): write to 0x400. Required: bresp=10 and no memory change. A read of 0x400 returns rresp=10 with r_data=0.
- Backpressure: hold rready=0 and bready=0 for 5 cycles. Required: rvalid, bvalid, r_data and bresp remain stable. arready and awready stay 0 until the handshakes complete.
- Collision and reset: an AR handshake on 0x20 on the same edge as a write commit to 0x20 with 0x5A5A5A5A over 0x0. Required: the read returns 0x0 and a later read returns 0x5A5A5A5A. Then drop rst while bvalid=1. Required: bvalid=0 immediately and a later read of 0x20 returns 0.
